// File: rtl/alu_writeback.sv
// Writeback stage behind the 32-bit ALU: buffers results, derives C/Z/N flags and
// drains each result to the register-file write port, splitting multiplies into lo/hi writes.
//
// state  | meaning
// S_IDLE | no write pending; pops x0-destined heads, launches the next low-word write
// S_LO   | low word presented on wb_*, waiting for wb_ready
// S_HI   | high word of a multiply presented on wb_*, waiting for wb_ready

module alu_writeback #(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [63:0]       in_result_i,
   input  logic [3:0]        in_ctrl_i,
   input  logic [ADDR_W-1:0] in_rd_i,
   output logic              wb_valid_o,
   input  logic              wb_ready_i,
   output logic [ADDR_W-1:0] wb_addr_o,
   output logic [31:0]       wb_data_o,
   output logic              wb_hi_o,
   output logic [2:0]        flags_o,
   output logic              busy_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_MUL = 4'b0010;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LO   = 2'd1,
      S_HI   = 2'd2
   } state_t;

   logic [63:0]       mem_result [DEPTH];
   logic [3:0]        mem_ctrl   [DEPTH];
   logic [ADDR_W-1:0] mem_rd     [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [2:0]        flags_q, flags_d;

   state_t            state_q;
   logic              wb_valid_q;
   logic [ADDR_W-1:0] wb_addr_q;
   logic [31:0]       wb_data_q;
   logic              wb_hi_q;

   logic              full, empty, push, pop;
   logic [63:0]       head_result;
   logic [ADDR_W-1:0] head_rd;
   logic              head_mul, head_has_hi;

   assign full        = (count_q == CNT_W'(DEPTH));
   assign empty       = (count_q == '0);
   assign push        = in_valid_i && !full;
   assign head_result = mem_result[rd_ptr_q];
   assign head_rd     = mem_rd[rd_ptr_q];
   assign head_mul    = (mem_ctrl[rd_ptr_q] == OP_MUL);
   // rd+1 wrapping to x0 means the high word has nowhere to go
   assign head_has_hi = head_mul && !(&head_rd);

   always_comb begin
      pop = 1'b0;
      unique case (state_q)
         S_IDLE:  pop = !empty && (head_rd == '0);
         S_LO:    pop = wb_ready_i && !head_has_hi;
         S_HI:    pop = wb_ready_i;
         default: pop = 1'b0;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_comb begin
      flags_d = flags_q;
      if (push) begin
         if (in_ctrl_i == OP_MUL) begin
            flags_d = {1'b0, (in_result_i == 64'd0), in_result_i[63]};
         end else begin
            flags_d = {(in_ctrl_i == OP_ADD) && in_result_i[32],
                       (in_result_i[31:0] == 32'd0), in_result_i[31]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_result[wr_ptr_q] <= in_result_i;
         mem_ctrl[wr_ptr_q]   <= in_ctrl_i;
         mem_rd[wr_ptr_q]     <= in_rd_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         flags_q  <= 3'b000;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         flags_q  <= flags_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wb_valid_q <= 1'b0;
         wb_addr_q  <= '0;
         wb_data_q  <= '0;
         wb_hi_q    <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (!empty && (head_rd != '0)) begin
                  wb_valid_q <= 1'b1;
                  wb_addr_q  <= head_rd;
                  wb_data_q  <= head_result[31:0];
                  wb_hi_q    <= 1'b0;
                  state_q    <= S_LO;
               end
            end
            S_LO: begin
               if (wb_ready_i) begin
                  if (head_has_hi) begin
                     wb_addr_q <= head_rd + 1'b1;
                     wb_data_q <= head_result[63:32];
                     wb_hi_q   <= 1'b1;
                     state_q   <= S_HI;
                  end else begin
                     wb_valid_q <= 1'b0;
                     state_q    <= S_IDLE;
                  end
               end
            end
            S_HI: begin
               if (wb_ready_i) begin
                  wb_valid_q <= 1'b0;
                  state_q    <= S_IDLE;
               end
            end
            default: begin
               wb_valid_q <= 1'b0;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready_o = !full;
   assign wb_valid_o = wb_valid_q;
   assign wb_addr_o  = wb_addr_q;
   assign wb_data_o  = wb_data_q;
   assign wb_hi_o    = wb_hi_q;
   assign flags_o    = flags_q;
   assign busy_o     = !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed scenarios plus randomized traffic scored against
// a queue of expected register-file writes derived from each accepted result.

module tb_alu_writeback;

   localparam int DEPTH  = 2;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [63:0]       in_result;
   logic [3:0]        in_ctrl;
   logic [ADDR_W-1:0] in_rd;
   logic              wb_valid;
   logic              wb_ready;
   logic [ADDR_W-1:0] wb_addr;
   logic [31:0]       wb_data;
   logic              wb_hi;
   logic [2:0]        flags;
   logic              busy;

   alu_writeback #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_result_i(in_result),
      .in_ctrl_i(in_ctrl), .in_rd_i(in_rd),
      .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_addr_o(wb_addr),
      .wb_data_o(wb_data), .wb_hi_o(wb_hi), .flags_o(flags), .busy_o(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      logic              hi;
   } wr_t;

   wr_t        exp_q[$];
   logic [2:0] exp_flags;
   int         n_tests = 0;
   int         n_fail  = 0;
   int         n_writes = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Architectural consequences of one accepted result: its flags and its writes.
   task automatic model_accept(input logic [63:0] r, input logic [3:0] c, input logic [ADDR_W-1:0] rd);
      wr_t w;
      if (c == 4'b0010) exp_flags = {1'b0, r == 64'd0, r[63]};
      else              exp_flags = {(c == 4'b0000) ? r[32] : 1'b0, r[31:0] == 32'd0, r[31]};
      if (rd != 0) begin
         w.addr = rd; w.data = r[31:0]; w.hi = 1'b0;
         exp_q.push_back(w);
         if (c == 4'b0010 && rd != {ADDR_W{1'b1}}) begin
            w.addr = rd + 1'b1; w.data = r[63:32]; w.hi = 1'b1;
            exp_q.push_back(w);
         end
      end
   endtask

   task automatic tick();
      logic acc, hs;
      wr_t  w;
      @(negedge clk);
      acc = in_valid && in_ready && !rst;
      hs  = wb_valid && wb_ready && !rst;
      if (hs) begin
         n_writes++;
         chk("write_expected", (exp_q.size() > 0) ? 64'd1 : 64'd0, 64'd1);
         if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("wb_addr", 64'(wb_addr), 64'(w.addr));
            chk("wb_data", 64'(wb_data), 64'(w.data));
            chk("wb_hi",   64'(wb_hi),   64'(w.hi));
         end
      end
      if (acc) model_accept(in_result, in_ctrl, in_rd);
      @(posedge clk);
      #1;
      if (acc) chk("flags", 64'(flags), 64'(exp_flags));
   endtask

   task automatic drive(input logic v, input logic [63:0] r, input logic [3:0] c, input logic [ADDR_W-1:0] rd);
      in_valid = v; in_result = r; in_ctrl = c; in_rd = rd;
   endtask

   logic [ADDR_W-1:0] snap_addr;
   logic [31:0]       snap_data;
   logic              snap_hi;

   initial begin
      rst = 1'b1; wb_ready = 1'b0; exp_flags = 3'b000;
      drive(1'b0, 64'd0, 4'd0, '0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rst_wb_valid", 64'(wb_valid), 64'd0);
      chk("rst_wb_addr",  64'(wb_addr),  64'd0);
      chk("rst_wb_data",  64'(wb_data),  64'd0);
      chk("rst_wb_hi",    64'(wb_hi),    64'd0);
      chk("rst_flags",    64'(flags),    64'd0);
      chk("rst_busy",     64'(busy),     64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // add with carry out and zero low word
      wb_ready = 1'b1;
      drive(1'b1, 64'h1_0000_0000, 4'b0000, 5'd3);
      tick();
      drive(1'b0, 64'd0, 4'd0, '0);
      chk("add_flags", 64'(flags), 64'b110);
      chk("add_valid_t", 64'(wb_valid), 64'd0);
      tick();
      chk("add_valid_t1", 64'(wb_valid), 64'd1);
      chk("add_addr", 64'(wb_addr), 64'd3);
      chk("add_data", 64'(wb_data), 64'd0);
      tick();
      chk("add_done", 64'(wb_valid), 64'd0);
      chk("add_busy", 64'(busy), 64'd0);

      // multiply split into low then high write
      drive(1'b1, 64'hFFFF_FFFF_0000_0001, 4'b0010, 5'd6);
      tick();
      drive(1'b0, 64'd0, 4'd0, '0);
      chk("mul_flags", 64'(flags), 64'b001);
      tick();
      chk("mul_lo_addr", 64'(wb_addr), 64'd6);
      chk("mul_lo_data", 64'(wb_data), 64'h0000_0001);
      chk("mul_lo_hi", 64'(wb_hi), 64'd0);
      tick();
      chk("mul_hi_addr", 64'(wb_addr), 64'd7);
      chk("mul_hi_data", 64'(wb_data), 64'hFFFF_FFFF);
      chk("mul_hi_hi", 64'(wb_hi), 64'd1);
      tick();
      chk("mul_done", 64'(wb_valid), 64'd0);

      // rd==0 discarded in one cycle
      drive(1'b1, 64'h1234, 4'b0001, 5'd0);
      tick();
      drive(1'b0, 64'd0, 4'd0, '0);
      chk("x0_busy_t", 64'(busy), 64'd1);
      tick();
      chk("x0_busy_t1", 64'(busy), 64'd0);
      chk("x0_valid", 64'(wb_valid), 64'd0);

      // mul to the last register loses its high word
      drive(1'b1, 64'hAAAA_5555_0000_0007, 4'b0010, 5'd31);
      tick();
      drive(1'b0, 64'd0, 4'd0, '0);
      tick();
      chk("mul31_addr", 64'(wb_addr), 64'd31);
      tick();
      chk("mul31_no_hi", 64'(wb_valid), 64'd0);
      chk("mul31_busy", 64'(busy), 64'd0);

      // backpressure: fill the buffer, third push must be refused
      wb_ready = 1'b0;
      n_writes = 0;
      drive(1'b1, 64'h0000_0000_0000_00A1, 4'b0000, 5'd10);
      tick();
      drive(1'b1, 64'h0000_0000_8000_00B2, 4'b0011, 5'd11);
      tick();
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_flags_b", 64'(flags), 64'b001);
      snap_addr = wb_addr; snap_data = wb_data; snap_hi = wb_hi;
      chk("bp_head_addr", 64'(snap_addr), 64'd10);
      drive(1'b1, 64'h0, 4'b0000, 5'd12);
      tick();
      drive(1'b0, 64'd0, 4'd0, '0);
      chk("bp_c_refused_flags", 64'(flags), 64'b001);
      for (int i = 0; i < 3; i++) tick();
      chk("bp_stable_valid", 64'(wb_valid), 64'd1);
      chk("bp_stable_addr", 64'(wb_addr), 64'(snap_addr));
      chk("bp_stable_data", 64'(wb_data), 64'(snap_data));
      chk("bp_stable_hi", 64'(wb_hi), 64'(snap_hi));
      wb_ready = 1'b1;
      for (int i = 0; i < 20 && (exp_q.size() != 0 || busy); i++) tick();
      chk("bp_write_count", 64'(n_writes), 64'd2);
      chk("bp_drained", 64'(exp_q.size()), 64'd0);

      // reset during the high-word write of a multiply
      drive(1'b1, 64'h0000_0003_0000_0004, 4'b0010, 5'd12);
      tick();
      drive(1'b0, 64'd0, 4'd0, '0);
      tick();
      tick();
      wb_ready = 1'b0;
      chk("mr_in_hi", 64'(wb_hi), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("mr_valid_async", 64'(wb_valid), 64'd0);
      chk("mr_flags_async", 64'(flags), 64'd0);
      exp_q.delete();
      exp_flags = 3'b000;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      tick();
      chk("mr_busy", 64'(busy), 64'd0);
      chk("mr_in_ready", 64'(in_ready), 64'd1);

      // randomized traffic with random backpressure
      for (int i = 0; i < 600; i++) begin
         logic [3:0]        c;
         logic [ADDR_W-1:0] rd;
         logic [63:0]       r;
         case ($urandom_range(0, 5))
            0: c = 4'b0000;
            1, 2: c = 4'b0010;
            3: c = 4'b0001;
            4: c = 4'b0100;
            default: c = 4'b0011;
         endcase
         case ($urandom_range(0, 9))
            0: rd = '0;
            1: rd = {ADDR_W{1'b1}};
            default: rd = ADDR_W'($urandom);
         endcase
         r = {$urandom, $urandom};
         if ($urandom_range(0, 7) == 0) r[31:0] = 32'd0;
         if ($urandom_range(0, 15) == 0) r = 64'd0;
         drive(($urandom_range(0, 2) != 0), r, c, rd);
         wb_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      drive(1'b0, 64'd0, 4'd0, '0);
      wb_ready = 1'b1;
      for (int i = 0; i < 60 && (exp_q.size() != 0 || busy); i++) tick();
      chk("rand_drained", 64'(exp_q.size()), 64'd0);
      chk("rand_busy", 64'(busy), 64'd0);
      chk("rand_in_ready", 64'(in_ready), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
